// File: rtl/i2c_frame_sequencer_pkg.sv
// i2c_frame_pkg: shared types and defaults for the I2C frame sequencer.
//   state_e        sequencer FSM states
//   *_DEFAULT      default slave address and watchdog limit
//   xor_checksum   XOR of the first n bytes of a zero-extended byte vector
package i2c_frame_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START_ISSUE,
        START_WAIT,
        WR_ISSUE,
        WR_WAIT,
        STOP_ISSUE,
        STOP_WAIT,
        DONE,
        ERROR
    } state_e;

    localparam logic [6:0]  SLV_ADDR_DEFAULT = 7'h2A;
    localparam int unsigned TIMEOUT_DEFAULT  = 20000;
    localparam int          MAX_BYTES        = 15;

    function automatic logic [7:0] xor_checksum(input logic [MAX_BYTES*8-1:0] data,
                                                input int n);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < n) acc = acc ^ data[i*8 +: 8];
        end
        return acc;
    endfunction

endpackage

// File: rtl/i2c_frame_sequencer_if.sv
// i2c_frame_sequencer_if: control bus between the frame sequencer and the
// I2C byte master.
//   m_ready    master idle or holding between bytes
//   m_tx_done  master finished shifting the current byte
//   m_tx_data  byte presented to the master
//   m_start    START request
//   m_stop     STOP request
//   m_i2c_en   qualifier for start/stop/write requests
// Modports: master = sequencer side (drives the controls),
//           slave  = I2C byte master side.
interface i2c_frame_sequencer_if;

    logic       m_ready;
    logic       m_tx_done;
    logic [7:0] m_tx_data;
    logic       m_start;
    logic       m_stop;
    logic       m_i2c_en;

    modport master (
        input  m_ready, m_tx_done,
        output m_tx_data, m_start, m_stop, m_i2c_en
    );

    modport slave (
        output m_ready, m_tx_done,
        input  m_tx_data, m_start, m_stop, m_i2c_en
    );

endinterface

// File: rtl/i2c_frame_sequencer_watchdog.sv
// i2c_watchdog: no-progress timer for the frame sequencer.
//   clk, reset   clock, async active-low reset
//   clear        restart from zero (state change)
//   enable       count this cycle (waiting on the master)
//   expire       count has reached TIMEOUT-1 while enabled
module i2c_watchdog #(
    parameter int unsigned TIMEOUT = 20000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    assign expire = enable && (cnt == LIMIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expire) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_frame_sequencer.sv
// i2c_frame_sequencer: sends one frame (START, address+W, NUM_BYTES payload
// bytes, optional XOR checksum, STOP) through an I2C byte master, pacing
// only on the master's ready/tx_done, with a watchdog that parks in ERROR.
// Optional feature macro: I2C_FRAME_CKSUM_EN appends the XOR checksum byte.
//   clk, reset  clock, async active-low reset (the master shares this reset)
//   send_req    frame request, accepted only while req_ready
//   send_data   payload, byte 0 in [7:0] goes first
//   req_ready   high in IDLE
//   busy        high outside IDLE
//   done        one-cycle pulse after STOP completes
//   err         watchdog error, held until reset
//   i2c         control bus to the I2C byte master
//
// state       | meaning
// IDLE        | waiting for send_req with master ready
// START_ISSUE | one-cycle START request
// START_WAIT  | waiting for master to reach hold after START
// WR_ISSUE    | one-cycle write request, master latches m_tx_data
// WR_WAIT     | waiting for tx_done then ready
// STOP_ISSUE  | one-cycle STOP request
// STOP_WAIT   | waiting for master to return to idle
// DONE        | done pulse
// ERROR       | watchdog expired, terminal until reset
module i2c_frame_sequencer
    import i2c_frame_pkg::*;
#(
    parameter int          NUM_BYTES = 4,
    parameter logic [6:0]  SLV_ADDR  = SLV_ADDR_DEFAULT,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   send_req,
    input  logic [NUM_BYTES*8-1:0] send_data,
    output logic                   req_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    i2c_frame_sequencer_if.master  i2c
);

`ifdef I2C_FRAME_CKSUM_EN
    localparam int LAST = NUM_BYTES + 1;
`else
    localparam int LAST = NUM_BYTES;
`endif
    localparam int IDX_W = 5;

    state_e                 state, state_next;
    logic [IDX_W-1:0]       idx, idx_next;
    logic [NUM_BYTES*8-1:0] frame_buf;
    logic                   load;
    logic                   seen_busy, seen_busy_next;
    logic                   seen_done, seen_done_next;
    logic                   in_wait;
    logic                   wd_clear;
    logic                   wd_expire;
    logic [7:0]             cur_byte;

`ifdef I2C_FRAME_CKSUM_EN
    logic [MAX_BYTES*8-1:0] buf_ext;
    logic [7:0]             cksum;

    always_comb begin
        buf_ext = '0;
        buf_ext[NUM_BYTES*8-1:0] = frame_buf;
        cksum = xor_checksum(buf_ext, NUM_BYTES);
    end
`endif

    always_comb begin
        cur_byte = 8'h00;
        if (idx == '0) cur_byte = {SLV_ADDR, 1'b0};
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (idx == IDX_W'(k + 1)) cur_byte = frame_buf[k*8 +: 8];
        end
`ifdef I2C_FRAME_CKSUM_EN
        if (idx == IDX_W'(LAST)) cur_byte = cksum;
`endif
    end

    assign in_wait  = (state == START_WAIT) || (state == WR_WAIT) || (state == STOP_WAIT);
    assign wd_clear = (state_next != state);

    i2c_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (wd_clear),
        .enable (in_wait),
        .expire (wd_expire)
    );

    // Progress is checked before the watchdog in every wait state, so a
    // master that answers on the last allowed cycle still wins.
    always_comb begin
        state_next     = state;
        idx_next       = idx;
        load           = 1'b0;
        seen_busy_next = seen_busy;
        seen_done_next = seen_done;

        case (state)
            IDLE: begin
                if (send_req && i2c.m_ready) begin
                    state_next = START_ISSUE;
                    idx_next   = '0;
                    load       = 1'b1;
                end
            end
            START_ISSUE: state_next = START_WAIT;
            START_WAIT: begin
                if (!i2c.m_ready) seen_busy_next = 1'b1;
                if (i2c.m_ready && seen_busy) state_next = WR_ISSUE;
                else if (wd_expire)           state_next = ERROR;
            end
            WR_ISSUE: state_next = WR_WAIT;
            WR_WAIT: begin
                if (!i2c.m_ready) seen_busy_next = 1'b1;
                // tx_done only counts once the master has visibly started
                // the byte, so a stale flag cannot complete it early.
                if (i2c.m_tx_done && (seen_busy || !i2c.m_ready)) seen_done_next = 1'b1;
                if (i2c.m_ready && seen_done) begin
                    if (idx == IDX_W'(LAST)) begin
                        state_next = STOP_ISSUE;
                    end else begin
                        state_next = WR_ISSUE;
                        idx_next   = idx + 1'b1;
                    end
                end else if (wd_expire) begin
                    state_next = ERROR;
                end
            end
            STOP_ISSUE: state_next = STOP_WAIT;
            STOP_WAIT: begin
                if (!i2c.m_ready) seen_busy_next = 1'b1;
                if (i2c.m_ready && seen_busy) state_next = DONE;
                else if (wd_expire)           state_next = ERROR;
            end
            DONE:    state_next = IDLE;
            ERROR:   state_next = ERROR;
            default: state_next = IDLE;
        endcase

        if (state_next != state) begin
            seen_busy_next = 1'b0;
            seen_done_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            idx       <= '0;
            frame_buf <= '0;
            seen_busy <= 1'b0;
            seen_done <= 1'b0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            seen_busy <= seen_busy_next;
            seen_done <= seen_done_next;
            if (load) frame_buf <= send_data;
        end
    end

    // Controls are asserted only in the one-cycle *_ISSUE states; an enable
    // left high while the master holds would launch an extra write.
    assign req_ready     = (state == IDLE);
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign err           = (state == ERROR);
    assign i2c.m_start   = (state == START_ISSUE);
    assign i2c.m_stop    = (state == STOP_ISSUE);
    assign i2c.m_i2c_en  = (state == START_ISSUE) || (state == WR_ISSUE) || (state == STOP_ISSUE);
    assign i2c.m_tx_data = (state == IDLE) ? 8'h00 : cur_byte;

endmodule

// File: tb/tb_i2c_frame_sequencer.sv
module tb_i2c_frame_sequencer;
    import i2c_frame_pkg::*;

    localparam int NB  = 4;
    localparam int TO  = 400;
    localparam int BIT = 20;
`ifdef I2C_FRAME_CKSUM_EN
    localparam int NBYTES_SENT = NB + 2;
`else
    localparam int NBYTES_SENT = NB + 1;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          send_req = 1'b0;
    logic [NB*8-1:0] send_data = '0;
    logic          req_ready, busy, done, err;

    i2c_frame_sequencer_if bus ();

    i2c_frame_sequencer #(.NUM_BYTES(NB), .SLV_ADDR(7'h2A), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .send_req  (send_req),
        .send_data (send_data),
        .req_ready (req_ready),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .i2c       (bus)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural I2C byte master -----------------------
    typedef enum {M_IDLE, M_START, M_HOLD, M_SHIFT, M_ACK, M_STUCK, M_STOP} mst_e;
    mst_e       mst;
    int         mcnt;
    int         byte_no;
    int         nack_no = -1;
    logic [7:0] cap_mem [0:127];
    int         cap_wr = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mst           <= M_IDLE;
            bus.m_ready   <= 1'b1;
            bus.m_tx_done <= 1'b0;
            mcnt          <= 0;
            byte_no       <= 0;
        end else begin
            bus.m_tx_done <= 1'b0;
            case (mst)
                M_IDLE: if (bus.m_start && bus.m_i2c_en) begin
                    mst <= M_START; bus.m_ready <= 1'b0; mcnt <= BIT; byte_no <= 0;
                end
                M_START: if (mcnt <= 1) begin mst <= M_HOLD; bus.m_ready <= 1'b1; end
                         else mcnt <= mcnt - 1;
                M_HOLD: begin
                    if (bus.m_i2c_en && bus.m_stop) begin
                        mst <= M_STOP; bus.m_ready <= 1'b0; mcnt <= BIT;
                    end else if (bus.m_i2c_en && !bus.m_start) begin
                        cap_mem[cap_wr[6:0]] <= bus.m_tx_data;
                        cap_wr  <= cap_wr + 1;
                        byte_no <= byte_no + 1;
                        bus.m_ready <= 1'b0; mcnt <= 8*BIT; mst <= M_SHIFT;
                    end
                end
                M_SHIFT: if (mcnt <= 1) begin
                    bus.m_tx_done <= 1'b1; mcnt <= BIT;
                    mst <= ((byte_no - 1) == nack_no) ? M_STUCK : M_ACK;
                end else mcnt <= mcnt - 1;
                M_ACK: if (mcnt <= 1) begin mst <= M_HOLD; bus.m_ready <= 1'b1; end
                       else mcnt <= mcnt - 1;
                M_STUCK: mst <= M_STUCK;
                M_STOP: if (mcnt <= 1) begin mst <= M_IDLE; bus.m_ready <= 1'b1; end
                        else mcnt <= mcnt - 1;
                default: mst <= M_IDLE;
            endcase
        end
    end

    // ---------------- event counters ------------------------------------
    int cyc = 0, start_cnt = 0, stop_cnt = 0, en_cnt = 0, done_cnt = 0, wr_cnt = 0;
    int wr_cyc [0:127];
    int err_cyc = 0;
    bit err_seen = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.m_start)  start_cnt <= start_cnt + 1;
        if (bus.m_stop)   stop_cnt  <= stop_cnt + 1;
        if (bus.m_i2c_en) en_cnt    <= en_cnt + 1;
        if (done)         done_cnt  <= done_cnt + 1;
        if (bus.m_i2c_en && !bus.m_start && !bus.m_stop) begin
            wr_cyc[wr_cnt[6:0]] <= cyc;
            wr_cnt <= wr_cnt + 1;
        end
        if (err && !err_seen) begin
            err_cyc  <= cyc;
            err_seen <= 1'b1;
        end
    end

    // ---------------- checking ------------------------------------------
    int         compared = 0;
    int         mismatched = 0;
    logic [7:0] exp_q [$];
    int         cap_rd = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [NB*8-1:0] data);
        logic [7:0] x;
        x = 8'h00;
        exp_q.push_back({7'h2A, 1'b0});
        for (int i = 0; i < NB; i++) begin
            exp_q.push_back(data[i*8 +: 8]);
            x = x ^ data[i*8 +: 8];
        end
`ifdef I2C_FRAME_CKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic check_bytes(input string tag);
        chk({tag, " byte count"}, 32'(cap_wr - cap_rd), 32'(exp_q.size()));
        while (exp_q.size() > 0 && cap_rd < cap_wr) begin
            chk({tag, " byte"}, 32'(cap_mem[cap_rd[6:0]]), 32'(exp_q.pop_front()));
            cap_rd++;
        end
        exp_q.delete();
        cap_rd = cap_wr;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, " busy"},      32'(busy),      32'd0);
        chk({tag, " done"},      32'(done),      32'd0);
        chk({tag, " err"},       32'(err),       32'd0);
        chk({tag, " m_start"},   32'(bus.m_start),  32'd0);
        chk({tag, " m_stop"},    32'(bus.m_stop),   32'd0);
        chk({tag, " m_i2c_en"},  32'(bus.m_i2c_en), 32'd0);
        chk({tag, " m_tx_data"}, 32'(bus.m_tx_data), 32'h00);
    endtask

    task automatic request(input string tag, input logic [NB*8-1:0] data);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        send_data = data;
        send_req  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (busy) begin ok = 1'b1; break; end
        end
        send_req = 1'b0;
        chk({tag, " accept timeout"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
        chk({tag, " done timeout"}, 32'(ok), 32'd1);
    endtask

    task automatic run_frame(input string tag, input logic [NB*8-1:0] data);
        int s0, p0, e0, d0;
        s0 = start_cnt; p0 = stop_cnt; e0 = en_cnt; d0 = done_cnt;
        push_frame(data);
        request(tag, data);
        wait_done(tag);
        @(negedge clk);
        chk({tag, " req_ready"},   32'(req_ready), 32'd1);
        chk({tag, " busy"},        32'(busy),      32'd0);
        chk({tag, " starts"},      32'(start_cnt - s0), 32'd1);
        chk({tag, " stops"},       32'(stop_cnt - p0),  32'd1);
        chk({tag, " done cycles"}, 32'(done_cnt - d0),  32'd1);
        chk({tag, " en cycles"},   32'(en_cnt - e0),    32'(NBYTES_SENT + 2));
        check_bytes(tag);
    endtask

    initial begin
        int s0, d0, w0, e0;
        bit ok;

        #12;
        check_reset_vals("reset");
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        run_frame("nominal", 32'hDDCCBBAA);
        run_frame("lsb",     32'h00000001);
        run_frame("pattern", 32'h80FF3C5A);

        // send_req held high across a frame: second START only after done
        s0 = start_cnt; d0 = done_cnt;
        push_frame(32'h11223344);
        push_frame(32'h11223344);
        @(negedge clk);
        send_data = 32'h11223344;
        send_req  = 1'b1;
        wait_done("b2b first");
        chk("b2b starts at first done", 32'(start_cnt - s0), 32'd1);
        @(negedge clk);
        wait_done("b2b second");
        send_req = 1'b0;
        @(negedge clk);
        chk("b2b starts", 32'(start_cnt - s0), 32'd2);
        chk("b2b dones",  32'(done_cnt - d0),  32'd2);
        check_bytes("b2b");

        // request pulse while busy is dropped, not queued
        s0 = start_cnt;
        push_frame(32'hCAFE0F0F);
        request("drop", 32'hCAFE0F0F);
        repeat (50) @(negedge clk);
        send_data = 32'h55555555;
        send_req  = 1'b1;
        @(negedge clk);
        send_req  = 1'b0;
        wait_done("drop");
        repeat (40) @(negedge clk);
        chk("drop starts", 32'(start_cnt - s0), 32'd1);
        chk("drop idle",   32'(busy), 32'd0);
        check_bytes("drop");

        // async reset in the middle of WR_WAIT
        w0 = wr_cnt;
        request("midreset", 32'hA5A5A5A5);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (wr_cnt >= w0 + 2 && !bus.m_ready) begin ok = 1'b1; break; end
        end
        chk("midreset reach wr_wait", 32'(ok), 32'd1);
        #2 reset = 1'b0;
        #1;
        check_reset_vals("midreset");
        @(negedge clk);
        reset = 1'b1;
        cap_rd = cap_wr;
        exp_q.delete();
        repeat (2) @(negedge clk);
        run_frame("after reset", 32'h12345678);

        // NACK on byte 2 leaves the master stuck; watchdog must fire
        nack_no = 2;
        w0 = wr_cnt;
        request("nack", 32'hDDCCBBAA);
        ok = 1'b0;
        for (int i = 0; i < 4 * TO + 2000; i++) begin
            @(negedge clk);
            if (err) begin ok = 1'b1; break; end
        end
        chk("nack err timeout", 32'(ok), 32'd1);
        @(negedge clk);
        chk("nack err delay", 32'(err_cyc - wr_cyc[(w0 + 2) & 127]), 32'(TO + 1));
        chk("nack state",     32'(dut.state), 32'(ERROR));
        chk("nack busy",      32'(busy), 32'd1);
        chk("nack req_ready", 32'(req_ready), 32'd0);
        s0 = start_cnt; e0 = en_cnt;
        send_req = 1'b1;
        repeat (300) @(negedge clk);
        send_req = 1'b0;
        chk("nack no starts", 32'(start_cnt - s0), 32'd0);
        chk("nack no enable", 32'(en_cnt - e0),    32'd0);
        chk("nack err held",  32'(err), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/i2c_frame_sequencer.md
Name: i2c_frame_sequencer

Overview:
- Upstream driver of the board-to-board I2C master. Accepts one game-state frame (NUM_BYTES payload bytes) from the game logic.
- Drives the master's start/stop/i2c_en/tx_data controls to send START, address+W, the payload bytes, an optional checksum byte, and STOP.
- Paces itself only from the master's ready and tx_done.
- Detects a stuck master (NACK, or no progress) with a watchdog and flags an error.

Parameters:
- NUM_BYTES, 4, payload bytes per frame (1..15).
- SLV_ADDR, 7'h2A, 7-bit slave address; the first byte sent is {SLV_ADDR,1'b0}.
- TIMEOUT, 20000, max clk cycles spent in any *_WAIT state before abort; must exceed the master's per-byte time of ~9000 clk.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- send_req  in  1  frame request; accepted only when req_ready=1.
- send_data  in  NUM_BYTES*8  payload; byte 0 = send_data[7:0], sent first.
- req_ready  out  1  high only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after STOP completes.
- err  out  1  sticky watchdog error; cleared only by reset.
- m_ready  in  1  master ready (high in master idle and in master hold).
- m_tx_done  in  1  master byte-shifted flag.
- m_tx_data  out  8  byte presented to the master.
- m_start  out  1  start request to the master.
- m_stop  out  1  stop request to the master.
- m_i2c_en  out  1  master enable qualifier.

Behaviour:
- Moore outputs, decoded from the registered state only.
- Reset values: state=IDLE, req_ready=1, busy/done/err/m_start/m_stop/m_i2c_en=0, m_tx_data=8'h00, byte index=0, watchdog=0, seen_busy=0.
- Reset mid-frame aborts immediately to IDLE. The top level holds the master in reset on the same event.
- Byte index idx counts 0..LAST with LAST=NUM_BYTES (or NUM_BYTES+1 with checksum). idx 0 = address byte; idx k = payload byte k-1.
- m_tx_data = frame byte[idx] in every state except IDLE.
- IDLE: send_req & m_ready -> latch send_data into frame buffer, idx=0, go to START_ISSUE. send_req while m_ready=0 is not accepted; requester keeps send_req high.
- START_ISSUE (1 cycle): m_start=1, m_i2c_en=1 -> START_WAIT.
- START_WAIT: all master controls 0.
  - Set seen_busy when m_ready=0.
  - On m_ready=1 with seen_busy=1 (master reached hold) -> WR_ISSUE, clear seen_busy.
- WR_ISSUE (1 cycle): m_i2c_en=1, m_start=0, m_stop=0 -> WR_WAIT. The master latches m_tx_data in this cycle.
- WR_WAIT: controls 0; seen_busy logic as in START_WAIT.
  - Completion requires m_tx_done=1 sampled while busy was seen, then m_ready=1.
  - On completion: idx==LAST -> STOP_ISSUE; else idx+1 -> WR_ISSUE.
- STOP_ISSUE (1 cycle): m_stop=1, m_i2c_en=1 -> STOP_WAIT.
- STOP_WAIT: wait for m_ready low then high (master back in idle) -> DONE.
- DONE (1 cycle): done=1 -> IDLE.
- Controls are never held high in a *_WAIT state. A lingering i2c_en with start=stop=0 in master hold would launch an unintended write.
- Watchdog:
  - Counter clears on every state change and counts in START_WAIT, WR_WAIT and STOP_WAIT.
  - Reaching TIMEOUT-1 -> ERROR.
  - ERROR: err=1, busy=1, controls 0, terminal until reset. A NACK leaves the master stuck in its ack state, so recovery requires reset.
- send_req during busy is ignored, with no queueing.
- Simultaneous m_ready=1 and the watchdog limit in the same cycle: progress wins.

Optional Feature:
- I2C_FRAME_CKSUM_EN defined: LAST=NUM_BYTES+1, and the extra final byte = XOR of all payload bytes, computed combinationally from the latched buffer.
- Undefined: LAST=NUM_BYTES, no checksum logic.

Decomposition:
- Package i2c_frame_pkg holds:
  - the state_e typedef (IDLE, START_ISSUE, START_WAIT, WR_ISSUE, WR_WAIT, STOP_ISSUE, STOP_WAIT, DONE, ERROR);
  - localparam defaults for SLV_ADDR and TIMEOUT;
  - a function computing the XOR checksum.
- Sub-module i2c_watchdog: counter with clear, enable and expire outputs, parameterised by TIMEOUT.

Test Plan:
- Bench setup: behavioural master model (ready/tx_done timing with FCOUNT=500, 1000-clk bits), slave ACKs.
- Nominal frame: send_data=32'hDDCCBBAA -> bytes 0x54, 0xAA, 0xBB, 0xCC, 0xDD on SDA, STOP, done pulse exactly once, req_ready back to 1.
- Checksum build: same data with I2C_FRAME_CKSUM_EN defined -> sixth byte is 0x00 (XOR); with data 32'h00000001 the checksum is 0x01.
- NACK on byte 2 -> master stalls; err=1 after TIMEOUT cycles; state ERROR; no further m_start/m_i2c_en pulses.
- Back-to-back requests: send_req held high across a frame -> second frame starts only after done, with one START per frame; a request while busy is dropped.
- Reset low mid-WR_WAIT -> all outputs at reset values within the same cycle (async); next frame after reset completes normally.
- Control hygiene check: m_i2c_en is high for exactly one cycle per byte, plus START and STOP (7 cycles total for NUM_BYTES=4 without checksum).
